spram_ctrl: RTL and testbench

SPRAM_CTRL -- requirements
Module: spram_ctrl

---
 rtl/spram_ctrl_pkg.sv | 22 ++
 rtl/spram_ctrl_if.sv | 32 +++
 rtl/spram_ctrl.sv | 146 ++++++++++++++
 tb/tb_spram_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// spram_ctrl_pkg: shared sizes and FSM state encoding for the single-port RAM controller.
// Rev 1.0
`default_nettype none

package spram_ctrl_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int ADR_W     = 8;
    localparam int DATA_W    = 8;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        WR_ACC = 3'd2,
        RD_ACC = 3'd3,
        RD_CAP = 3'd4,
        CLR    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spram_ctrl_if.sv
// spram_ctrl_if: user-side request/response, zero-fill and status signals of spram_ctrl.
// Rev 1.0
`default_nettype none

interface spram_ctrl_if;
    import spram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADR_W-1:0]  req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_adr, req_wdata, clr_start,
        input  req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done, init_done
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_wdata, clr_start,
        output req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done, init_done
    );

endinterface

`default_nettype wire

// File: rtl/spram_ctrl.sv
// spram_ctrl: single-port RAM controller with power-up quiet period, 2/3-cycle accesses and zero-fill.
// Rev 1.0
`default_nettype none

module spram_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 100
) (
    input  wire                CLK,
    input  wire                RN,
    spram_ctrl_if.slave        bus,
    output logic               ram_ENB,
    output logic               ram_WEB,
    output logic               ram_OEB,
    output logic [ADR_W-1:0]   ram_ADR,
    output logic [DATA_W-1:0]  ram_D,
    input  wire  [DATA_W-1:0]  ram_Q
);

    // One counter times INIT and walks the fill addresses, so it must cover both ranges.
    localparam int CNT_W = ($clog2(INIT_CYCLES) > ADR_W) ? $clog2(INIT_CYCLES) : ADR_W;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(RAM_DEPTH - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              clr_busy_q;
    logic              clr_done_q;
    logic              init_done_q;
    logic              ram_enb_q;
    logic              ram_web_q;
    logic              ram_oeb_q;
    logic [ADR_W-1:0]  ram_adr_q;
    logic [DATA_W-1:0] ram_d_q;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            init_done_q <= 1'b0;
            ram_enb_q   <= 1'b1;
            ram_web_q   <= 1'b1;
            ram_oeb_q   <= 1'b1;
            ram_adr_q   <= '0;
            ram_d_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            clr_done_q  <= 1'b0;
            case (state_q)
                INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE: begin
                    // A zero-fill request wins over a simultaneous access request.
                    if (bus.clr_start) begin
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        clr_busy_q  <= 1'b1;
                        ram_enb_q   <= 1'b0;
                        ram_web_q   <= 1'b0;
                        ram_adr_q   <= '0;
                        ram_d_q     <= '0;
                        state_q     <= CLR;
                    end else if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        ram_enb_q   <= 1'b0;
                        ram_adr_q   <= bus.req_adr;
                        if (bus.req_we) begin
                            ram_web_q <= 1'b0;
                            ram_d_q   <= bus.req_wdata;
                            state_q   <= WR_ACC;
                        end else begin
                            ram_oeb_q <= 1'b0;
                            state_q   <= RD_ACC;
                        end
                    end
                end
                WR_ACC: begin
                    ram_enb_q   <= 1'b1;
                    ram_web_q   <= 1'b1;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                RD_ACC: begin
                    ram_enb_q <= 1'b1;
                    state_q   <= RD_CAP;
                end
                RD_CAP: begin
                    rsp_rdata_q <= ram_Q;
                    rsp_valid_q <= 1'b1;
                    ram_oeb_q   <= 1'b1;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                CLR: begin
                    if (cnt_q == CLR_LAST) begin
                        ram_enb_q   <= 1'b1;
                        ram_web_q   <= 1'b1;
                        clr_busy_q  <= 1'b0;
                        clr_done_q  <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q     <= cnt_d;
                        ram_adr_q <= cnt_d[ADR_W-1:0];
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.clr_done  = clr_done_q;
    assign bus.init_done = init_done_q;
    assign ram_ENB       = ram_enb_q;
    assign ram_WEB       = ram_web_q;
    assign ram_OEB       = ram_oeb_q;
    assign ram_ADR       = ram_adr_q;
    assign ram_D         = ram_d_q;

endmodule

`default_nettype wire

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: self-checking bench for spram_ctrl with a behavioural RAM and reference memory.
// Rev 1.0
`default_nettype none

module tb_spram_ctrl;
    import spram_ctrl_pkg::*;

    localparam int INIT_CYCLES = 100;

    logic       CLK = 1'b0;
    logic       RN;
    logic       ram_ENB, ram_WEB, ram_OEB;
    logic [7:0] ram_ADR, ram_D, ram_Q;

    spram_ctrl_if bus();

    spram_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
        .CLK     (CLK),
        .RN      (RN),
        .bus     (bus),
        .ram_ENB (ram_ENB),
        .ram_WEB (ram_WEB),
        .ram_OEB (ram_OEB),
        .ram_ADR (ram_ADR),
        .ram_D   (ram_D),
        .ram_Q   (ram_Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port RAM; output bus shows junk unless output-enabled.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_q_r = 8'h00;
    always @(posedge CLK) begin
        if (!ram_ENB) begin
            if (!ram_WEB) ram_mem[ram_ADR] <= ram_D;
            else          ram_q_r <= ram_mem[ram_ADR];
        end
    end
    assign ram_Q = ram_OEB ? 8'hEE : ram_q_r;

    logic [7:0] ref_mem [256];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.req_ready && k < 400) begin
            @(negedge CLK);
            k++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ram_ctl"}, {ram_ENB, ram_WEB, ram_OEB}, 3'b111);
        check({tag, "_ram_adr_d"}, {ram_ADR, ram_D}, 16'h0000);
        check({tag, "_status"}, {bus.req_ready, bus.rsp_valid, bus.clr_busy, bus.clr_done, bus.init_done}, 5'b0);
        check({tag, "_rdata"}, bus.rsp_rdata, 8'h00);
    endtask

    // Called at the negedge where RN has just been released.
    task automatic init_window();
        int bad = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_adr   = 8'h00;
        repeat (INIT_CYCLES - 1) begin
            @(negedge CLK);
            if (!ram_ENB || !ram_WEB || !ram_OEB || bus.req_ready || bus.init_done) bad++;
        end
        check("init_quiet_errs", bad, 0);
        @(negedge CLK);
        check("init_done", bus.init_done, 1);
        check("init_ready", bus.req_ready, 1);
        check("init_enb", ram_ENB, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] adr, input logic [7:0] data);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = adr;
        bus.req_wdata = data;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("wr_strobe", {ram_ENB, ram_WEB, ram_OEB, bus.req_ready}, 4'b0010);
        check("wr_adr_d", {ram_ADR, ram_D}, {adr, data});
        @(negedge CLK);
        check("wr_release", {ram_ENB, bus.req_ready}, 2'b11);
        ref_mem[adr] = data;
    endtask

    task automatic do_read(input logic [7:0] adr, output logic [7:0] got);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_adr   = adr;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("rd_strobe", {ram_ENB, ram_WEB, ram_OEB, bus.rsp_valid}, 4'b0100);
        check("rd_adr", ram_ADR, adr);
        @(negedge CLK);
        check("rd_e1", {ram_ENB, ram_OEB, bus.rsp_valid}, 3'b100);
        @(negedge CLK);
        check("rd_rsp_valid", {bus.rsp_valid, ram_OEB}, 2'b11);
        got = bus.rsp_rdata;
        @(negedge CLK);
        check("rd_pulse_end", bus.rsp_valid, 0);
        check("rd_hold", bus.rsp_rdata, got);
    endtask

    task automatic read_expect(input string name, input logic [7:0] adr, input logic [7:0] exp);
        logic [7:0] got;
        do_read(adr, got);
        check(name, got, exp);
    endtask

    task automatic do_clear(input bit with_write);
        int busy_n = 0;
        int bad    = 0;
        wait_ready();
        bus.clr_start = 1'b1;
        if (with_write) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_adr   = 8'h10;
            bus.req_wdata = 8'h77;
        end
        @(negedge CLK);
        bus.clr_start = 1'b0;
        bus.req_valid = 1'b0;
        while (bus.clr_busy && busy_n < 300) begin
            if (ram_ENB || ram_WEB || ram_ADR != 8'(busy_n) || ram_D != 8'h00 || bus.req_ready) bad++;
            busy_n++;
            @(negedge CLK);
        end
        check("clr_busy_cycles", busy_n, 256);
        check("clr_strobe_errs", bad, 0);
        check("clr_done_pulse", {bus.clr_done, ram_ENB, bus.req_ready}, 3'b111);
        @(negedge CLK);
        check("clr_done_once", bus.clr_done, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic b2b_reads();
        int         cyc = 0;
        int         n_acc = 0;
        int         n_rsp = 0;
        int         acc_cyc [2];
        int         rsp_cyc [2];
        logic [7:0] rsp_dat [2];
        bit         pend = 0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_adr   = 8'h01;
        for (int i = 0; i < 16; i++) begin
            if (pend) begin
                pend = 0;
                if (n_acc == 1) bus.req_adr = 8'h02;
                else            bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid && n_rsp < 2) begin
                rsp_cyc[n_rsp] = cyc;
                rsp_dat[n_rsp] = bus.rsp_rdata;
                n_rsp++;
            end
            if (bus.req_valid && bus.req_ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                pend = 1;
            end
            @(negedge CLK);
            cyc++;
        end
        bus.req_valid = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_rsps", n_rsp, 2);
        if (n_acc == 2 && n_rsp == 2) begin
            check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 3);
            check("b2b_latency", rsp_cyc[0] - acc_cyc[0], 3);
            check("b2b_data0", rsp_dat[0], ref_mem[1]);
            check("b2b_data1", rsp_dat[1], ref_mem[2]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] a;
        logic [7:0] d;
        int         r;

        tbl[0]  = '{1'b1, 8'h05, 8'h11};
        tbl[1]  = '{1'b1, 8'h06, 8'h22};
        tbl[2]  = '{1'b0, 8'h05, 8'h11};
        tbl[3]  = '{1'b0, 8'h06, 8'h22};
        tbl[4]  = '{1'b1, 8'h05, 8'h33};
        tbl[5]  = '{1'b0, 8'h05, 8'h33};
        tbl[6]  = '{1'b0, 8'h07, 8'h00};
        tbl[7]  = '{1'b1, 8'hFF, 8'h80};
        tbl[8]  = '{1'b0, 8'hFF, 8'h80};
        tbl[9]  = '{1'b1, 8'h00, 8'h01};
        tbl[10] = '{1'b0, 8'h00, 8'h01};
        tbl[11] = '{1'b0, 8'h06, 8'h22};

        RN            = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_adr   = 8'h00;
        bus.req_wdata = 8'h00;
        bus.clr_start = 1'b0;

        // Power-up: 20 ns of reset with a request held, then the quiet period.
        @(negedge CLK);
        check_reset_values("por");
        @(negedge CLK);
        RN = 1'b1;
        init_window();

        // Write then read back.
        do_write(8'h3C, 8'hA5);
        read_expect("wr_rd_3c", 8'h3C, 8'hA5);

        // Zero-fill wipes both ends of the address space.
        do_write(8'h00, 8'hFF);
        do_write(8'hFF, 8'hFF);
        do_clear(1'b0);
        read_expect("clr_adr00", 8'h00, 8'h00);
        read_expect("clr_adrff", 8'hFF, 8'h00);

        // Zero-fill and write requested together: the write is dropped.
        do_write(8'h10, 8'h55);
        do_clear(1'b1);
        read_expect("simul_adr10", 8'h10, 8'h00);

        // clr_start seen outside IDLE is ignored.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_adr   = 8'h20;
        bus.req_wdata = 8'h5A;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.clr_start = 1'b1;
        @(negedge CLK);
        bus.clr_start = 1'b0;
        ref_mem[8'h20] = 8'h5A;
        check("clr_ignored", {bus.clr_busy, bus.req_ready}, 2'b01);
        @(negedge CLK);
        check("clr_ignored_late", {bus.clr_busy, ram_ENB}, 2'b01);
        read_expect("clr_ignored_data", 8'h20, 8'h5A);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].we) do_write(tbl[i].adr, tbl[i].data);
            else           read_expect("tbl_rd", tbl[i].adr, tbl[i].data);
        end

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 59));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (r == 0)       do_clear(1'b0);
            else if (r < 30)  do_write(a, d);
            else              read_expect("rand_rd", a, ref_mem[a]);
        end

        do_write(8'h01, 8'hB1);
        do_write(8'h02, 8'hB2);
        b2b_reads();

        // Reset during a fill: addresses already written stay zero, the rest are untouched.
        do_write(8'hC8, 8'hC8);
        wait_ready();
        bus.clr_start = 1'b1;
        @(negedge CLK);
        bus.clr_start = 1'b0;
        repeat (100) @(negedge CLK);
        check("midfill_adr", {ram_ENB, ram_ADR}, {1'b0, 8'd100});
        #2;
        RN = 1'b0;
        #1;
        check_reset_values("midfill_rst");
        @(negedge CLK);
        RN = 1'b1;
        for (int i = 0; i < 100; i++) ref_mem[i] = 8'h00;
        init_window();
        read_expect("abort_adr00", 8'h00, 8'h00);
        read_expect("abort_adr63", 8'h63, 8'h00);
        read_expect("abort_adrc8", 8'hC8, 8'hC8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
